regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Brief    : Two-requester (ALU / load unit) register-file writeback arbiter
//            with alternating priority, a registered write port and a
//            per-register pending-write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_a_rd,
  input  logic [31:0] alu_rd,
  output logic        alu_ready,
  input  logic        lsu_valid,
  input  logic [4:0]  lsu_a_rd,
  input  logic [31:0] lsu_rd,
  output logic        lsu_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_a_rd,
  output logic [4:0]  a_rd,
  output logic [31:0] rd,
  output logic        we,
  output logic [31:0] busy
);

  // prio_q = 1 favours the ALU, 0 favours the load unit
  logic        prio_q;
  logic        prio_d;
  logic [4:0]  a_rd_q;
  logic [31:0] rd_q;
  logic        we_q;
  logic [31:0] busy_q;
  logic [31:0] busy_d;

  logic        w_accept;
  logic [4:0]  w_addr;
  logic [31:0] w_data;

  // Grant: a lone requester always wins; on contention prio_q picks; nothing is
  // granted while reset is held.
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (!rst) begin
      alu_ready = alu_valid && (!lsu_valid || prio_q);
      lsu_ready = lsu_valid && (!alu_valid || !prio_q);
    end
  end

  // Select the granted payload and compute the priority for the next cycle
  always_comb begin
    w_accept = alu_ready || lsu_ready;
    w_addr   = alu_ready ? alu_a_rd : lsu_a_rd;
    w_data   = alu_ready ? alu_rd   : lsu_rd;
    prio_d   = prio_q;
    if (lsu_ready) begin
      prio_d = 1'b1;
    end else if (alu_ready) begin
      prio_d = 1'b0;
    end
  end

  // Scoreboard next state: clear on accepted write, then set on issue so a
  // same-edge set wins; x0 is never tracked.
  always_comb begin
    busy_d = busy_q;
    if (w_accept) begin
      busy_d[w_addr] = 1'b0;
    end
    if (iss_valid && (iss_a_rd != 5'd0)) begin
      busy_d[iss_a_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Output stage, priority and scoreboard registers
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
      a_rd_q <= 5'd0;
      rd_q   <= 32'd0;
      we_q   <= 1'b0;
      busy_q <= 32'd0;
    end else begin
      prio_q <= prio_d;
      busy_q <= busy_d;
      we_q   <= w_accept && (w_addr != 5'd0);
      if (w_accept) begin
        a_rd_q <= w_addr;
        rd_q   <= w_data;
      end
    end
  end

  assign a_rd = a_rd_q;
  assign rd   = rd_q;
  assign we   = we_q;
  assign busy = busy_q;

endmodule
`default_nettype wire
